cpu_exec_control: RTL and testbench
===================================

# cpu_exec_control

Combined execute/control core of the 32-bit accumulator-less register CPU: a multi-cycle control FSM, a 32-bit ALU, and a branch/conditional-move unit. It sits between the instruction register/register bank and the PC register/shared memory bus. It decodes opcode/function fields, sequences fetch/execute/memory cycles, computes ALU results and the next PC, and raises halt/power status.

## Interface
Parameters: none; all widths are fixed at 32 bits.

Ports (clock and reset first):
- clk  in  1  single system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- resume  in  1  leave the HALT state when high.
- opcode  in  4  instruction bits [31:28].
- funct  in  4  instruction bits [27:24]; ALU function, or branch condition.
- a  in  32  rs1 value.
- b  in  32  second operand, already muxed: rs2 or sign-extended imm.
- pc_inc  in  32  PC+1.
- load_pc  out  1  PC register load enable.
- load_ins  out  1  instruction register load enable.
- write_reg  out  1  register-bank write enable.
- mem_en  out  1  data-memory access cycle; when 0, the bus carries the instruction fetch.
- mem_wen  out  1  data-memory write; only high together with mem_en.
- imm_sel  out  1  selects imm as the b source.
- data_sel  out  2  write-back source: 0 = ALU, 1 = memory, 2 = cmov, 3 = zero.
- alu_out  out  32  ALU result; also the data-memory address.
- npc  out  32  next PC value.
- cmov  out  32  conditional-move result.
- pwr  out  1  high whenever the block is out of reset.
- halted  out  1  high in the HALT state.

## Operation
Opcodes:
- 0 ALU reg-reg.
- 1 ALU imm (imm_sel=1).
- 2 LD: rd ← mem[a+imm].
- 3 ST: mem[a+imm] ← rd.
- 4 BR: imm_sel=1.
- 5 CMOV: data_sel=2.
- 6 NOP.
- 7 HALT.
- 8–15: execute as NOP.

ALU function source:
- Opcodes 0 and 1 use funct.
- Opcodes 2 and 3 force ADD.

ALU funct encodings (results mod 2^32):
- 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR.
- 6 SLL, 7 SRL, 8 SRA; shift amount is b[4:0].
- 9 SLT signed, 10 SLTU; result is 1 or 0.
- 11 LUI: b<<16.
- 12 NOT a, 13 a+1, 14 a−1.
- 15 HAM: popcount(a).

Branch conditions (opcode 4, funct[2:0], a treated as signed):
- 0 always, 1 a==0, 2 a!=0, 3 a<0, 4 a>0, 5–7 never.
- Taken: npc = pc_inc + b (wraps mod 2^32). Otherwise npc = pc_inc.
- For every non-branch opcode, npc = pc_inc.

cmov = (signed a < signed b) ? a : b. Always driven combinationally.

FSM states: FETCH, EXEC, MEM, HALT.
- FETCH: load_ins=1, mem_en=0 → EXEC.
- EXEC, ALU/CMOV: write_reg=1, load_pc=1 → FETCH.
- EXEC, BR/NOP: load_pc=1 → FETCH.
- EXEC, LD/ST: no enables → MEM.
- EXEC, HALT: no enables → HALT.
- MEM: mem_en=1.
  - LD: data_sel=1, write_reg=1, load_pc=1.
  - ST: mem_wen=1, load_pc=1.
  - Next state → FETCH.
- HALT: halted=1. If resume=1: load_pc=1 (npc = pc_inc) → FETCH; otherwise stay in HALT.
- imm_sel and data_sel are decoded from opcode in every state.
- All unlisted enables are 0.

## Timing
- Reset (reset=0 at an edge): state ← FETCH.
- While reset is low, all enables are forced to 0, and pwr=0 and halted=0.
- Reset low mid-instruction aborts that instruction; no write occurs.
- First FETCH follows the first edge with reset=1.
- Instruction latency:
  - ALU, CMOV, BR, NOP: 2 cycles.
  - LD, ST: 3 cycles.
  - HALT: 2 cycles to reach HALT, then 1 cycle after resume is sampled.
- resume held high across multiple cycles resumes only once per HALT entry.
- resume is ignored outside HALT.
- alu_out, npc and cmov are purely combinational from their inputs.
- Control outputs are combinational from state and opcode; they are glitch-tolerant only at clock edges.

## Configuration
- Macro: CPU_EXEC_HAM_EN.
- Defined: funct 15 computes popcount(a).
- Undefined: funct 15 returns 32'd0, and no popcount logic is synthesized.

## Structure
- Package cpu_exec_pkg holds:
  - opcode localparams,
  - ALU funct localparams,
  - branch-condition codes,
  - FSM state typedef,
  - data_sel codes.
- One sub-module, cpu_exec_alu: the combinational ALU including the HAM option.
- FSM, branch unit and cmov logic stay in the top module.

## Test plan
- Reset low for 2 cycles → pwr=0, all enables 0. Release → FETCH with load_ins=1, mem_en=0.
- opcode 0, funct 1, a=5, b=7 → alu_out=32'hFFFFFFFE. EXEC has write_reg=1, load_pc=1, data_sel=0.
- opcode 4, funct 1, a=0, b=32'hFFFFFFFC, pc_inc=10 → npc=6. Same test with a=3 → npc=10.
- opcode 2, a=100, b=4 → EXEC has no enables. MEM has mem_en=1, mem_wen=0, data_sel=1, write_reg=1, alu_out=104. opcode 3 → MEM has mem_wen=1, write_reg=0.
- opcode 7 → halted=1 held for 5 cycles with resume=0. Pulse resume → load_pc=1, then FETCH.
- opcode 0, funct 15, a=32'hF0F0000F → alu_out=12 with CPU_EXEC_HAM_EN defined, 0 without. opcode 5, a=−3, b=2 → cmov=32'hFFFFFFFD.

Source files
------------

// File: rtl/cpu_exec_pkg.sv
// Shared definitions for the execute/control core: opcode, ALU function and
// branch-condition codes, write-back source codes, the control FSM state type
// and a popcount helper used when CPU_EXEC_HAM_EN is defined.
package cpu_exec_pkg;

    // Opcodes, instruction bits [31:28]
    localparam logic [3:0] OP_ALU_R = 4'd0;
    localparam logic [3:0] OP_ALU_I = 4'd1;
    localparam logic [3:0] OP_LD    = 4'd2;
    localparam logic [3:0] OP_ST    = 4'd3;
    localparam logic [3:0] OP_BR    = 4'd4;
    localparam logic [3:0] OP_CMOV  = 4'd5;
    localparam logic [3:0] OP_NOP   = 4'd6;
    localparam logic [3:0] OP_HALT  = 4'd7;

    // ALU function codes, instruction bits [27:24]
    localparam logic [3:0] FN_ADD  = 4'd0;
    localparam logic [3:0] FN_SUB  = 4'd1;
    localparam logic [3:0] FN_AND  = 4'd2;
    localparam logic [3:0] FN_OR   = 4'd3;
    localparam logic [3:0] FN_XOR  = 4'd4;
    localparam logic [3:0] FN_NOR  = 4'd5;
    localparam logic [3:0] FN_SLL  = 4'd6;
    localparam logic [3:0] FN_SRL  = 4'd7;
    localparam logic [3:0] FN_SRA  = 4'd8;
    localparam logic [3:0] FN_SLT  = 4'd9;
    localparam logic [3:0] FN_SLTU = 4'd10;
    localparam logic [3:0] FN_LUI  = 4'd11;
    localparam logic [3:0] FN_NOT  = 4'd12;
    localparam logic [3:0] FN_INC  = 4'd13;
    localparam logic [3:0] FN_DEC  = 4'd14;
    localparam logic [3:0] FN_HAM  = 4'd15;

    // Branch conditions, funct[2:0] of a BR instruction (a is signed)
    localparam logic [2:0] BC_ALWAYS = 3'd0;
    localparam logic [2:0] BC_EQZ    = 3'd1;
    localparam logic [2:0] BC_NEZ    = 3'd2;
    localparam logic [2:0] BC_LTZ    = 3'd3;
    localparam logic [2:0] BC_GTZ    = 3'd4;

    // Register write-back source select
    localparam logic [1:0] DS_ALU  = 2'd0;
    localparam logic [1:0] DS_MEM  = 2'd1;
    localparam logic [1:0] DS_CMOV = 2'd2;
    localparam logic [1:0] DS_ZERO = 2'd3;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_MEM   = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    // Number of set bits in a 32-bit word
    function automatic logic [31:0] popcount32(input logic [31:0] v);
        logic [31:0] cnt;
        cnt = 32'd0;
        for (int i = 0; i < 32; i++) begin
            cnt = cnt + {31'd0, v[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/cpu_exec_control_if.sv
// Bundle of the instruction, operand and control signals between the
// sequencing side (register bank / IR / PC / bus) and cpu_exec_control.
interface cpu_exec_control_if;
    logic        resume;
    logic [3:0]  opcode;
    logic [3:0]  funct;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] pc_inc;
    logic        load_pc;
    logic        load_ins;
    logic        write_reg;
    logic        mem_en;
    logic        mem_wen;
    logic        imm_sel;
    logic [1:0]  data_sel;
    logic [31:0] alu_out;
    logic [31:0] npc;
    logic [31:0] cmov;
    logic        pwr;
    logic        halted;

    // Side that supplies instruction fields and operands
    modport master (
        output resume, opcode, funct, a, b, pc_inc,
        input  load_pc, load_ins, write_reg, mem_en, mem_wen, imm_sel,
               data_sel, alu_out, npc, cmov, pwr, halted
    );

    // The execute/control core
    modport slave (
        input  resume, opcode, funct, a, b, pc_inc,
        output load_pc, load_ins, write_reg, mem_en, mem_wen, imm_sel,
               data_sel, alu_out, npc, cmov, pwr, halted
    );
endinterface

// File: rtl/cpu_exec_alu.sv
// Combinational 32-bit ALU. Macro CPU_EXEC_HAM_EN enables funct 15 as a
// popcount of a; without it funct 15 yields zero and no popcount is built.
module cpu_exec_alu
    import cpu_exec_pkg::*;
(
    input  logic [3:0]  i_fn,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_y
);

    // Select the result of the requested function
    always_comb begin
        o_y = 32'd0;
        case (i_fn)
            FN_ADD:  o_y = i_a + i_b;
            FN_SUB:  o_y = i_a - i_b;
            FN_AND:  o_y = i_a & i_b;
            FN_OR:   o_y = i_a | i_b;
            FN_XOR:  o_y = i_a ^ i_b;
            FN_NOR:  o_y = ~(i_a | i_b);
            FN_SLL:  o_y = i_a << i_b[4:0];
            FN_SRL:  o_y = i_a >> i_b[4:0];
            FN_SRA:  o_y = $signed(i_a) >>> i_b[4:0];
            FN_SLT:  o_y = {31'd0, ($signed(i_a) < $signed(i_b))};
            FN_SLTU: o_y = {31'd0, (i_a < i_b)};
            FN_LUI:  o_y = i_b << 16;
            FN_NOT:  o_y = ~i_a;
            FN_INC:  o_y = i_a + 32'd1;
            FN_DEC:  o_y = i_a - 32'd1;
`ifdef CPU_EXEC_HAM_EN
            FN_HAM:  o_y = popcount32(i_a);
`else
            FN_HAM:  o_y = 32'd0;
`endif
            default: o_y = 32'd0;
        endcase
    end

endmodule

// File: rtl/cpu_exec_control.sv
// Execute/control core: multi-cycle FETCH/EXEC/MEM/HALT sequencer, ALU
// (cpu_exec_alu), branch next-PC unit and conditional move. Optional macro
// CPU_EXEC_HAM_EN (consumed by the ALU) enables the popcount function.
module cpu_exec_control
    import cpu_exec_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    cpu_exec_control_if.slave bus
);

    state_t      r_state;
    state_t      w_next_state;
    logic        w_load_pc;
    logic        w_load_ins;
    logic        w_write_reg;
    logic        w_mem_en;
    logic        w_mem_wen;
    logic        w_halted;
    logic [3:0]  w_alu_fn;
    logic [31:0] w_alu_out;
    logic        w_taken;

    // Loads and stores compute their address with ADD regardless of funct
    assign w_alu_fn = ((bus.opcode == OP_LD) || (bus.opcode == OP_ST)) ? FN_ADD : bus.funct;

    cpu_exec_alu u_alu (
        .i_fn (w_alu_fn),
        .i_a  (bus.a),
        .i_b  (bus.b),
        .o_y  (w_alu_out)
    );

    assign bus.alu_out = w_alu_out;
    assign bus.cmov    = ($signed(bus.a) < $signed(bus.b)) ? bus.a : bus.b;

    // Evaluate the branch condition on a signed view of a
    always_comb begin
        w_taken = 1'b0;
        case (bus.funct[2:0])
            BC_ALWAYS: w_taken = 1'b1;
            BC_EQZ:    w_taken = (bus.a == 32'd0);
            BC_NEZ:    w_taken = (bus.a != 32'd0);
            BC_LTZ:    w_taken = bus.a[31];
            BC_GTZ:    w_taken = !bus.a[31] && (bus.a != 32'd0);
            default:   w_taken = 1'b0;
        endcase
    end

    assign bus.npc = ((bus.opcode == OP_BR) && w_taken) ? (bus.pc_inc + bus.b) : bus.pc_inc;

    // Source selects depend only on the opcode, in every state
    assign bus.imm_sel  = (bus.opcode == OP_ALU_I) || (bus.opcode == OP_LD) ||
                          (bus.opcode == OP_ST)    || (bus.opcode == OP_BR);
    assign bus.data_sel = (bus.opcode == OP_LD)   ? DS_MEM  :
                          (bus.opcode == OP_CMOV) ? DS_CMOV : DS_ALU;

    // Control state register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and enable decode
    always_comb begin
        w_next_state = r_state;
        w_load_pc    = 1'b0;
        w_load_ins   = 1'b0;
        w_write_reg  = 1'b0;
        w_mem_en     = 1'b0;
        w_mem_wen    = 1'b0;
        w_halted     = 1'b0;
        case (r_state)
            ST_FETCH: begin
                w_load_ins   = 1'b1;
                w_next_state = ST_EXEC;
            end
            ST_EXEC: begin
                case (bus.opcode)
                    OP_ALU_R, OP_ALU_I, OP_CMOV: begin
                        w_write_reg  = 1'b1;
                        w_load_pc    = 1'b1;
                        w_next_state = ST_FETCH;
                    end
                    OP_LD, OP_ST: begin
                        w_next_state = ST_MEM;
                    end
                    OP_HALT: begin
                        w_next_state = ST_HALT;
                    end
                    default: begin
                        // BR, NOP and the unused opcodes just advance the PC
                        w_load_pc    = 1'b1;
                        w_next_state = ST_FETCH;
                    end
                endcase
            end
            ST_MEM: begin
                w_mem_en     = 1'b1;
                w_load_pc    = 1'b1;
                w_next_state = ST_FETCH;
                if (bus.opcode == OP_LD) begin
                    w_write_reg = 1'b1;
                end else if (bus.opcode == OP_ST) begin
                    w_mem_wen = 1'b1;
                end else begin
                    w_write_reg = 1'b0;
                end
            end
            ST_HALT: begin
                w_halted = 1'b1;
                if (bus.resume) begin
                    w_load_pc    = 1'b1;
                    w_next_state = ST_FETCH;
                end else begin
                    w_next_state = ST_HALT;
                end
            end
            default: begin
                w_next_state = ST_FETCH;
            end
        endcase
    end

    // Reset low masks every enable and status flag immediately
    assign bus.load_pc   = reset & w_load_pc;
    assign bus.load_ins  = reset & w_load_ins;
    assign bus.write_reg = reset & w_write_reg;
    assign bus.mem_en    = reset & w_mem_en;
    assign bus.mem_wen   = reset & w_mem_wen;
    assign bus.halted    = reset & w_halted;
    assign bus.pwr       = reset;

endmodule

// File: tb/tb_cpu_exec_control.sv
// Self-checking bench for cpu_exec_control: a table of datapath vectors
// (ALU, branch next-PC, cmov) plus hand-written multi-cycle control sequences.
module tb_cpu_exec_control;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    cpu_exec_control_if bus ();

    cpu_exec_control dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {load_pc, load_ins, write_reg, mem_en, mem_wen, halted}
    logic [5:0] en;
    assign en = {bus.load_pc, bus.load_ins, bus.write_reg, bus.mem_en, bus.mem_wen, bus.halted};

    localparam logic [31:0] HAM_EXP =
`ifdef CPU_EXEC_HAM_EN
        32'd12;
`else
        32'd0;
`endif

    typedef struct {
        logic [3:0]  op;
        logic [3:0]  fn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] pc;
        logic        chk_alu;
        logic [31:0] e_alu;
        logic [31:0] e_npc;
        logic [31:0] e_cmov;
    } vec_t;

    vec_t vecs[31];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic setin(input logic [3:0] op, input logic [3:0] fn,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] pc);
        bus.opcode = op;
        bus.funct  = fn;
        bus.a      = a;
        bus.b      = b;
        bus.pc_inc = pc;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset      = 1'b0;
        bus.resume = 1'b0;
        setin(4'd0, 4'd1, 32'd5, 32'd7, 32'd10);

        //            op    fn     a              b              pc            chk   alu            npc            cmov
        vecs[0]  = '{4'd0, 4'd0,  32'd5,         32'd7,         32'd10,       1'b1, 32'd12,        32'd10,        32'd5};
        vecs[1]  = '{4'd0, 4'd1,  32'd5,         32'd7,         32'd10,       1'b1, 32'hFFFFFFFE,  32'd10,        32'd5};
        vecs[2]  = '{4'd0, 4'd2,  32'hF0F000FF,  32'h0FF00F0F,  32'd10,       1'b1, 32'h00F0000F,  32'd10,        32'hF0F000FF};
        vecs[3]  = '{4'd1, 4'd3,  32'hF0000000,  32'h0000000F,  32'd10,       1'b1, 32'hF000000F,  32'd10,        32'hF0000000};
        vecs[4]  = '{4'd0, 4'd4,  32'hFFFF0000,  32'h0F0F0F0F,  32'd10,       1'b1, 32'hF0F00F0F,  32'd10,        32'hFFFF0000};
        vecs[5]  = '{4'd0, 4'd5,  32'd0,         32'd1,         32'd10,       1'b1, 32'hFFFFFFFE,  32'd10,        32'd0};
        vecs[6]  = '{4'd0, 4'd6,  32'd1,         32'h24,        32'd10,       1'b1, 32'd16,        32'd10,        32'd1};
        vecs[7]  = '{4'd0, 4'd7,  32'h80000000,  32'd4,         32'd10,       1'b1, 32'h08000000,  32'd10,        32'h80000000};
        vecs[8]  = '{4'd0, 4'd8,  32'h80000000,  32'd4,         32'd10,       1'b1, 32'hF8000000,  32'd10,        32'h80000000};
        vecs[9]  = '{4'd0, 4'd9,  32'hFFFFFFFF,  32'd1,         32'd10,       1'b1, 32'd1,         32'd10,        32'hFFFFFFFF};
        vecs[10] = '{4'd0, 4'd10, 32'hFFFFFFFF,  32'd1,         32'd10,       1'b1, 32'd0,         32'd10,        32'hFFFFFFFF};
        vecs[11] = '{4'd1, 4'd11, 32'd0,         32'h1234,      32'd10,       1'b1, 32'h12340000,  32'd10,        32'd0};
        vecs[12] = '{4'd0, 4'd12, 32'h0000FFFF,  32'd0,         32'd10,       1'b1, 32'hFFFF0000,  32'd10,        32'd0};
        vecs[13] = '{4'd0, 4'd13, 32'hFFFFFFFF,  32'd0,         32'd10,       1'b1, 32'd0,         32'd10,        32'hFFFFFFFF};
        vecs[14] = '{4'd0, 4'd14, 32'd0,         32'd0,         32'd10,       1'b1, 32'hFFFFFFFF,  32'd10,        32'd0};
        vecs[15] = '{4'd0, 4'd15, 32'hF0F0000F,  32'd0,         32'd10,       1'b1, HAM_EXP,       32'd10,        32'hF0F0000F};
        vecs[16] = '{4'd2, 4'd5,  32'd100,       32'd4,         32'd10,       1'b1, 32'd104,       32'd10,        32'd4};
        vecs[17] = '{4'd3, 4'd1,  32'd100,       32'd4,         32'd10,       1'b1, 32'd104,       32'd10,        32'd4};
        vecs[18] = '{4'd4, 4'd1,  32'd0,         32'hFFFFFFFC,  32'd10,       1'b0, 32'd0,         32'd6,         32'hFFFFFFFC};
        vecs[19] = '{4'd4, 4'd1,  32'd3,         32'hFFFFFFFC,  32'd10,       1'b0, 32'd0,         32'd10,        32'hFFFFFFFC};
        vecs[20] = '{4'd4, 4'd0,  32'd3,         32'd20,        32'd10,       1'b0, 32'd0,         32'd30,        32'd3};
        vecs[21] = '{4'd4, 4'd2,  32'd3,         32'd20,        32'd10,       1'b0, 32'd0,         32'd30,        32'd3};
        vecs[22] = '{4'd4, 4'd3,  32'hFFFFFFFF,  32'd20,        32'd10,       1'b0, 32'd0,         32'd30,        32'hFFFFFFFF};
        vecs[23] = '{4'd4, 4'd4,  32'd0,         32'd20,        32'd10,       1'b0, 32'd0,         32'd10,        32'd0};
        vecs[24] = '{4'd4, 4'd4,  32'd1,         32'd20,        32'd10,       1'b0, 32'd0,         32'd30,        32'd1};
        vecs[25] = '{4'd4, 4'd5,  32'd0,         32'd20,        32'd10,       1'b0, 32'd0,         32'd10,        32'd0};
        vecs[26] = '{4'd4, 4'd8,  32'd5,         32'd20,        32'd10,       1'b0, 32'd0,         32'd30,        32'd5};
        vecs[27] = '{4'd4, 4'd3,  32'd0,         32'd20,        32'd10,       1'b0, 32'd0,         32'd10,        32'd0};
        vecs[28] = '{4'd4, 4'd0,  32'd0,         32'hFFFFFFF0,  32'd5,        1'b0, 32'd0,         32'hFFFFFFF5,  32'hFFFFFFF0};
        vecs[29] = '{4'd5, 4'd0,  32'hFFFFFFFD,  32'd2,         32'd10,       1'b0, 32'd0,         32'd10,        32'hFFFFFFFD};
        vecs[30] = '{4'd6, 4'd0,  32'd9,         32'd20,        32'd77,       1'b0, 32'd0,         32'd77,        32'd9};

        // Reset held for two cycles
        nxt();
        nxt();
        @(negedge clk);
        chk("reset_pwr", {31'd0, bus.pwr}, 32'd0);
        chk("reset_enables", {26'd0, en}, 32'd0);

        // Datapath table, applied while reset keeps the FSM parked
        for (int i = 0; i < 31; i++) begin
            setin(vecs[i].op, vecs[i].fn, vecs[i].a, vecs[i].b, vecs[i].pc);
            @(negedge clk);
            if (vecs[i].chk_alu) begin
                chk($sformatf("vec%0d_alu", i), bus.alu_out, vecs[i].e_alu);
            end else begin
                chk($sformatf("vec%0d_en_in_reset", i), {26'd0, en}, 32'd0);
            end
            chk($sformatf("vec%0d_npc", i), bus.npc, vecs[i].e_npc);
            chk($sformatf("vec%0d_cmov", i), bus.cmov, vecs[i].e_cmov);
            nxt();
        end

        // Release reset: FETCH then ALU SUB
        setin(4'd0, 4'd1, 32'd5, 32'd7, 32'd10);
        reset = 1'b1;
        @(negedge clk);
        chk("fetch_en", {26'd0, en}, 32'b010000);
        chk("fetch_pwr", {31'd0, bus.pwr}, 32'd1);
        nxt(); @(negedge clk);
        chk("alu_exec_en", {26'd0, en}, 32'b101000);
        chk("alu_exec_ds", {30'd0, bus.data_sel}, 32'd0);
        chk("alu_exec_imm", {31'd0, bus.imm_sel}, 32'd0);
        chk("alu_exec_out", bus.alu_out, 32'hFFFFFFFE);

        // LD: FETCH, EXEC (idle), MEM
        nxt(); setin(4'd2, 4'd0, 32'd100, 32'd4, 32'd10);
        @(negedge clk); chk("ld_fetch_en", {26'd0, en}, 32'b010000);
        nxt(); @(negedge clk); chk("ld_exec_en", {26'd0, en}, 32'b000000);
        nxt(); @(negedge clk);
        chk("ld_mem_en", {26'd0, en}, 32'b101100);
        chk("ld_mem_ds", {30'd0, bus.data_sel}, 32'd1);
        chk("ld_mem_addr", bus.alu_out, 32'd104);

        // ST
        nxt(); setin(4'd3, 4'd0, 32'd100, 32'd4, 32'd10);
        @(negedge clk); chk("st_fetch_en", {26'd0, en}, 32'b010000);
        nxt(); @(negedge clk); chk("st_exec_en", {26'd0, en}, 32'b000000);
        nxt(); @(negedge clk); chk("st_mem_en", {26'd0, en}, 32'b100110);

        // BR taken
        nxt(); setin(4'd4, 4'd1, 32'd0, 32'hFFFFFFFC, 32'd10);
        @(negedge clk); chk("br_fetch_en", {26'd0, en}, 32'b010000);
        nxt(); @(negedge clk);
        chk("br_exec_en", {26'd0, en}, 32'b100000);
        chk("br_exec_npc", bus.npc, 32'd6);
        chk("br_exec_imm", {31'd0, bus.imm_sel}, 32'd1);

        // NOP with resume high outside HALT (ignored)
        nxt(); setin(4'd6, 4'd0, 32'd0, 32'd0, 32'd11); bus.resume = 1'b1;
        @(negedge clk); chk("nop_fetch_en", {26'd0, en}, 32'b010000);
        nxt(); @(negedge clk); chk("nop_exec_en", {26'd0, en}, 32'b100000);

        // Unused opcode behaves as NOP
        nxt(); setin(4'd12, 4'd0, 32'd0, 32'd0, 32'd12); bus.resume = 1'b0;
        @(negedge clk); chk("op12_fetch_en", {26'd0, en}, 32'b010000);
        nxt(); @(negedge clk); chk("op12_exec_en", {26'd0, en}, 32'b100000);

        // CMOV
        nxt(); setin(4'd5, 4'd0, 32'hFFFFFFFD, 32'd2, 32'd13);
        @(negedge clk); chk("cmov_fetch_en", {26'd0, en}, 32'b010000);
        nxt(); @(negedge clk);
        chk("cmov_exec_en", {26'd0, en}, 32'b101000);
        chk("cmov_exec_ds", {30'd0, bus.data_sel}, 32'd2);
        chk("cmov_exec_val", bus.cmov, 32'hFFFFFFFD);

        // HALT held for five cycles, then a resume pulse
        nxt(); setin(4'd7, 4'd0, 32'd0, 32'd0, 32'd14);
        @(negedge clk); chk("halt_fetch_en", {26'd0, en}, 32'b010000);
        nxt(); @(negedge clk); chk("halt_exec_en", {26'd0, en}, 32'b000000);
        for (int k = 0; k < 5; k++) begin
            nxt(); @(negedge clk);
            chk($sformatf("halt_hold%0d_en", k), {26'd0, en}, 32'b000001);
        end
        nxt(); bus.resume = 1'b1;
        @(negedge clk);
        chk("halt_resume_en", {26'd0, en}, 32'b100001);
        chk("halt_resume_npc", bus.npc, 32'd14);
        nxt(); @(negedge clk); chk("resume_held_fetch_en", {26'd0, en}, 32'b010000);
        nxt(); @(negedge clk); chk("resume_held_exec_en", {26'd0, en}, 32'b000000);
        nxt(); @(negedge clk); chk("halt2_resume_en", {26'd0, en}, 32'b100001);
        nxt(); bus.resume = 1'b0; setin(4'd0, 4'd0, 32'd1, 32'd2, 32'd15);
        @(negedge clk); chk("after_halt_fetch_en", {26'd0, en}, 32'b010000);
        nxt(); @(negedge clk); chk("after_halt_exec_en", {26'd0, en}, 32'b101000);

        // Reset during MEM aborts the load
        nxt(); setin(4'd2, 4'd0, 32'd100, 32'd4, 32'd16);
        nxt(); nxt();
        reset = 1'b0;
        @(negedge clk);
        chk("abort_en", {26'd0, en}, 32'b000000);
        chk("abort_pwr", {31'd0, bus.pwr}, 32'd0);
        nxt(); reset = 1'b1;
        @(negedge clk); chk("abort_refetch_en", {26'd0, en}, 32'b010000);
        nxt(); @(negedge clk); chk("abort_reexec_en", {26'd0, en}, 32'b000000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
